// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute/write-back control sequencer
//               with program counter, condition flags and halt/run control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  input  logic [1:0]          operation,
  input  logic [2:0]          jump_instruction,
  input  logic [2:0]          jump_offset,
  input  logic                alu_zero,
  input  logic                alu_neg,
  output logic                alu_en,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halt,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } seqState_t;

  localparam logic [1:0] c_opAlu   = 2'b00;
  localparam logic [1:0] c_opShift = 2'b01;
  localparam logic [1:0] c_opJump  = 2'b10;

  seqState_t           r_state;
  seqState_t           w_nextState;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_instr;
  logic                r_flagZ;
  logic                r_flagN;
  logic                r_imemReq;
  logic                r_aluEn;
  logic                r_rfWe;
  logic                r_halt;
  logic                r_busy;
  logic                w_jumpTaken;
  logic [PC_WIDTH-1:0] w_pcInc;
  logic [PC_WIDTH-1:0] w_offsetExt;

  assign w_pcInc     = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign w_offsetExt = {{(PC_WIDTH-3){jump_offset[2]}}, jump_offset};

  // Conditions read the registered flags, so a jump sees the last write-back.
  always_comb begin
    w_jumpTaken = 1'b0;
    case (jump_instruction)
      3'b001:  w_jumpTaken = 1'b1;
      3'b010:  w_jumpTaken = r_flagZ;
      3'b011:  w_jumpTaken = !r_flagZ;
      3'b100:  w_jumpTaken = r_flagN;
      3'b101:  w_jumpTaken = !r_flagN;
      default: w_jumpTaken = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      w_nextState = run ? FETCH : IDLE;
      FETCH:     w_nextState = imem_ack ? DECODE : FETCH;
      DECODE:    w_nextState = EXECUTE;
      EXECUTE: begin
        case (operation)
          c_opAlu, c_opShift: w_nextState = WRITEBACK;
          c_opJump:           w_nextState = FETCH;
          default:            w_nextState = HALT;
        endcase
      end
      WRITEBACK: w_nextState = FETCH;
      HALT:      w_nextState = run ? FETCH : HALT;
      default:   w_nextState = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_flagZ   <= 1'b0;
      r_flagN   <= 1'b0;
      r_imemReq <= 1'b0;
      r_aluEn   <= 1'b0;
      r_rfWe    <= 1'b0;
      r_halt    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_imemReq <= (w_nextState == FETCH);
      r_aluEn   <= (w_nextState == EXECUTE);
      r_rfWe    <= (w_nextState == WRITEBACK);
      r_halt    <= (w_nextState == HALT);
      r_busy    <= (w_nextState == FETCH) || (w_nextState == DECODE) ||
                   (w_nextState == EXECUTE) || (w_nextState == WRITEBACK);

      if (r_state == FETCH && imem_ack) begin
        r_instr <= imem_rdata;
      end

      if (r_state == EXECUTE) begin
        if (operation == c_opJump) begin
          r_pc <= w_jumpTaken ? (r_pc + w_offsetExt) : w_pcInc;
        end else if (operation == 2'b11) begin
          r_pc <= w_pcInc;
        end
      end

      if (r_state == WRITEBACK) begin
        r_pc    <= w_pcInc;
        r_flagZ <= alu_zero;
        r_flagN <= alu_neg;
      end
    end
  end

  assign imem_req  = r_imemReq;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign alu_en    = r_aluEn;
  assign rf_we     = r_rfWe;
  assign halt      = r_halt;
  assign busy      = r_busy;

endmodule

`default_nettype wire
